// File: rtl/mfp_loader_arb_pkg.sv
// Shared types and constants for the core/loader AHB-Lite bus arbiter.
// Imported by the arbiter top and its master mux.
package mfp_loader_arb_pkg;

   typedef enum logic [1:0] {
      ST_RELEASE    = 2'd0,
      ST_CPU_OWN    = 2'd1,
      ST_DRAIN      = 2'd2,
      ST_LOADER_OWN = 2'd3
   } arb_state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic {
      OWN_CPU    = 1'b0,
      OWN_LOADER = 1'b1
   } owner_t;

   typedef struct packed {
      logic [31:0] haddr;
      logic [2:0]  hburst;
      logic        hmastlock;
      logic [3:0]  hprot;
      logic [2:0]  hsize;
      logic [1:0]  htrans;
      logic [31:0] hwdata;
      logic        hwrite;
   } ahb_master_t;

endpackage

// File: rtl/mfp_ahb_master_mux.sv
// Two-way AHB-Lite master mux: address/control follow the address-phase owner,
// HWDATA follows the registered data-phase owner.
module mfp_ahb_master_mux
   import mfp_loader_arb_pkg::*;
(
   input  owner_t      addr_owner,
   input  owner_t      data_owner,
   input  logic        force_idle,
   input  ahb_master_t cpu_m,
   input  ahb_master_t loader_m,
   output ahb_master_t bus_m
);

   always_comb begin
      bus_m = (addr_owner == OWN_CPU) ? cpu_m : loader_m;
      bus_m.hwdata = (data_owner == OWN_CPU) ? cpu_m.hwdata : loader_m.hwdata;
      if (force_idle) begin
         bus_m.htrans = HTRANS_IDLE;
      end
   end

endmodule

// File: rtl/mfp_loader_bus_arbiter.sv
// Shares the AHB-Lite master port between the MIPS core and the S-record loader,
// holding the core in reset while the loader owns the bus.
module mfp_loader_bus_arbiter
   import mfp_loader_arb_pkg::*;
#(
   parameter int unsigned RELEASE_CYCLES = 16
)(
   input  logic        HCLK,
   input  logic        HRESETn,

   input  logic [31:0] cpu_HADDR,
   input  logic [2:0]  cpu_HBURST,
   input  logic        cpu_HMASTLOCK,
   input  logic [3:0]  cpu_HPROT,
   input  logic [2:0]  cpu_HSIZE,
   input  logic [1:0]  cpu_HTRANS,
   input  logic [31:0] cpu_HWDATA,
   input  logic        cpu_HWRITE,
   output logic        cpu_HREADY,

   input  logic [31:0] loader_HADDR,
   input  logic [2:0]  loader_HBURST,
   input  logic        loader_HMASTLOCK,
   input  logic [3:0]  loader_HPROT,
   input  logic [2:0]  loader_HSIZE,
   input  logic [1:0]  loader_HTRANS,
   input  logic [31:0] loader_HWDATA,
   input  logic        loader_HWRITE,
   input  logic        loader_Busy,

   output logic [31:0] HADDR,
   output logic [2:0]  HBURST,
   output logic        HMASTLOCK,
   output logic [3:0]  HPROT,
   output logic [2:0]  HSIZE,
   output logic [1:0]  HTRANS,
   output logic [31:0] HWDATA,
   output logic        HWRITE,
   input  logic        HREADY,

   output logic        cpu_reset_n,
   output logic [7:0]  load_count,
   output logic        loader_overrun
);

   localparam logic [15:0] RELEASE_TC = 16'(RELEASE_CYCLES - 1);

   arb_state_t  state;
   logic [15:0] counter;
   owner_t      dp_owner;
   owner_t      addr_owner;
   logic        force_idle;
   ahb_master_t cpu_m;
   ahb_master_t loader_m;
   ahb_master_t bus_m;

   assign cpu_m = '{haddr: cpu_HADDR, hburst: cpu_HBURST, hmastlock: cpu_HMASTLOCK,
                    hprot: cpu_HPROT, hsize: cpu_HSIZE, htrans: cpu_HTRANS,
                    hwdata: cpu_HWDATA, hwrite: cpu_HWRITE};

   assign loader_m = '{haddr: loader_HADDR, hburst: loader_HBURST, hmastlock: loader_HMASTLOCK,
                       hprot: loader_HPROT, hsize: loader_HSIZE, htrans: loader_HTRANS,
                       hwdata: loader_HWDATA, hwrite: loader_HWRITE};

   // DRAIN keeps the CPU as address owner so its completing write keeps its data.
   assign addr_owner = (state == ST_CPU_OWN || state == ST_DRAIN) ? OWN_CPU : OWN_LOADER;
   assign force_idle = (state == ST_DRAIN) || !HRESETn;
   assign cpu_HREADY = (state == ST_CPU_OWN) && HREADY;

   mfp_ahb_master_mux u_mux (
      .addr_owner (addr_owner),
      .data_owner (dp_owner),
      .force_idle (force_idle),
      .cpu_m      (cpu_m),
      .loader_m   (loader_m),
      .bus_m      (bus_m)
   );

   assign HADDR     = bus_m.haddr;
   assign HBURST    = bus_m.hburst;
   assign HMASTLOCK = bus_m.hmastlock;
   assign HPROT     = bus_m.hprot;
   assign HSIZE     = bus_m.hsize;
   assign HTRANS    = bus_m.htrans;
   assign HWDATA    = bus_m.hwdata;
   assign HWRITE    = bus_m.hwrite;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state          <= ST_RELEASE;
         counter        <= '0;
         dp_owner       <= OWN_LOADER;
         cpu_reset_n    <= 1'b0;
         load_count     <= '0;
         loader_overrun <= 1'b0;
      end else begin
         if (HREADY) begin
            dp_owner <= addr_owner;
         end
         case (state)
            ST_RELEASE: begin
               // A busy loader wins over the terminal count on the same edge.
               if (loader_Busy) begin
                  state   <= ST_LOADER_OWN;
                  counter <= '0;
               end else if (counter == RELEASE_TC) begin
                  state       <= ST_CPU_OWN;
                  counter     <= '0;
                  cpu_reset_n <= 1'b1;
               end else begin
                  counter <= counter + 16'd1;
               end
            end
            ST_CPU_OWN: begin
               if (loader_Busy) begin
                  state       <= ST_DRAIN;
                  cpu_reset_n <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (loader_HTRANS != HTRANS_IDLE) begin
                  loader_overrun <= 1'b1;
               end
               if (HREADY) begin
                  state <= ST_LOADER_OWN;
               end
            end
            ST_LOADER_OWN: begin
               if (!loader_Busy) begin
                  state      <= ST_RELEASE;
                  counter    <= '0;
                  load_count <= load_count + 8'd1;
               end
            end
            default: begin
               state       <= ST_RELEASE;
               counter     <= '0;
               cpu_reset_n <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mfp_loader_bus_arbiter.sv
// Scoreboard bench for mfp_loader_bus_arbiter: a driver pushes model-predicted
// outputs per cycle, a negedge monitor pops and compares them.
module tb_mfp_loader_bus_arbiter;
   import mfp_loader_arb_pkg::*;

   localparam int unsigned RC = 16;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [31:0] cpu_HADDR, loader_HADDR, HADDR;
   logic [2:0]  cpu_HBURST, loader_HBURST, HBURST;
   logic        cpu_HMASTLOCK, loader_HMASTLOCK, HMASTLOCK;
   logic [3:0]  cpu_HPROT, loader_HPROT, HPROT;
   logic [2:0]  cpu_HSIZE, loader_HSIZE, HSIZE;
   logic [1:0]  cpu_HTRANS, loader_HTRANS, HTRANS;
   logic [31:0] cpu_HWDATA, loader_HWDATA, HWDATA;
   logic        cpu_HWRITE, loader_HWRITE, HWRITE;
   logic        cpu_HREADY, loader_Busy, HREADY;
   logic        cpu_reset_n, loader_overrun;
   logic [7:0]  load_count;

   always #5 HCLK = ~HCLK;

   mfp_loader_bus_arbiter #(.RELEASE_CYCLES(RC)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cpu_HADDR(cpu_HADDR), .cpu_HBURST(cpu_HBURST), .cpu_HMASTLOCK(cpu_HMASTLOCK),
      .cpu_HPROT(cpu_HPROT), .cpu_HSIZE(cpu_HSIZE), .cpu_HTRANS(cpu_HTRANS),
      .cpu_HWDATA(cpu_HWDATA), .cpu_HWRITE(cpu_HWRITE), .cpu_HREADY(cpu_HREADY),
      .loader_HADDR(loader_HADDR), .loader_HBURST(loader_HBURST),
      .loader_HMASTLOCK(loader_HMASTLOCK), .loader_HPROT(loader_HPROT),
      .loader_HSIZE(loader_HSIZE), .loader_HTRANS(loader_HTRANS),
      .loader_HWDATA(loader_HWDATA), .loader_HWRITE(loader_HWRITE),
      .loader_Busy(loader_Busy),
      .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
      .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
      .HREADY(HREADY),
      .cpu_reset_n(cpu_reset_n), .load_count(load_count), .loader_overrun(loader_overrun)
   );

   typedef struct {
      bit          rstn;
      bit          busy;
      bit          hready;
      ahb_master_t cpu;
      ahb_master_t ld;
   } stim_t;

   typedef struct {
      ahb_master_t bus;
      bit          cpu_hready;
      bit          cpu_reset_n;
      bit [7:0]    loads;
      bit          overrun;
   } exp_t;

   exp_t  q[$];
   stim_t cur, prev;
   int    n_total = 0;
   int    n_pass  = 0;

   // Reference model: who holds the bus, and cycles left before the core runs.
   bit          m_cpu_run, m_drain, m_loader_bus, m_dp_cpu, m_overrun;
   int unsigned m_wait_left;
   bit [7:0]    m_loads;

   function automatic void model_reset();
      m_cpu_run = 0; m_drain = 0; m_loader_bus = 0; m_dp_cpu = 0;
      m_overrun = 0; m_wait_left = RC; m_loads = 0;
   endfunction

   function automatic void model_step(stim_t p);
      if (!p.rstn) begin
         model_reset();
         return;
      end
      if (p.hready) m_dp_cpu = m_cpu_run || m_drain;
      if (m_drain && p.ld.htrans != 2'b00) m_overrun = 1;
      if (m_cpu_run) begin
         if (p.busy) begin m_cpu_run = 0; m_drain = 1; end
      end else if (m_drain) begin
         if (p.hready) begin m_drain = 0; m_loader_bus = 1; end
      end else if (m_loader_bus) begin
         if (!p.busy) begin m_loader_bus = 0; m_wait_left = RC; m_loads = m_loads + 8'd1; end
      end else begin
         if (p.busy) m_loader_bus = 1;
         else if (m_wait_left == 1) m_cpu_run = 1;
         else m_wait_left = m_wait_left - 1;
      end
   endfunction

   function automatic exp_t model_expect(stim_t s);
      exp_t e;
      bit   cpu_addr;
      cpu_addr = m_cpu_run || m_drain;
      e.bus = cpu_addr ? s.cpu : s.ld;
      e.bus.hwdata = m_dp_cpu ? s.cpu.hwdata : s.ld.hwdata;
      if (m_drain || !s.rstn) e.bus.htrans = 2'b00;
      e.cpu_hready  = m_cpu_run && s.hready;
      e.cpu_reset_n = m_cpu_run;
      e.loads       = m_loads;
      e.overrun     = m_overrun;
      return e;
   endfunction

   function automatic ahb_master_t rand_m();
      ahb_master_t m;
      m.haddr = $urandom; m.hburst = 3'($urandom); m.hmastlock = 1'($urandom);
      m.hprot = 4'($urandom); m.hsize = 3'($urandom); m.htrans = 2'($urandom);
      m.hwdata = $urandom; m.hwrite = 1'($urandom);
      return m;
   endfunction

   task automatic apply(stim_t s);
      HRESETn = s.rstn; loader_Busy = s.busy; HREADY = s.hready;
      cpu_HADDR = s.cpu.haddr; cpu_HBURST = s.cpu.hburst; cpu_HMASTLOCK = s.cpu.hmastlock;
      cpu_HPROT = s.cpu.hprot; cpu_HSIZE = s.cpu.hsize; cpu_HTRANS = s.cpu.htrans;
      cpu_HWDATA = s.cpu.hwdata; cpu_HWRITE = s.cpu.hwrite;
      loader_HADDR = s.ld.haddr; loader_HBURST = s.ld.hburst; loader_HMASTLOCK = s.ld.hmastlock;
      loader_HPROT = s.ld.hprot; loader_HSIZE = s.ld.hsize; loader_HTRANS = s.ld.htrans;
      loader_HWDATA = s.ld.hwdata; loader_HWRITE = s.ld.hwrite;
   endtask

   bit dir_cpu_wr, dir_ld_wr;

   task automatic step(input bit rstn, input bit busy, input bit hready, input logic [1:0] ld_tr);
      @(posedge HCLK);
      model_step(prev);
      #1;
      cur.rstn = rstn; cur.busy = busy; cur.hready = hready;
      cur.cpu = rand_m();
      cur.ld  = rand_m();
      cur.ld.htrans = ld_tr;
      if (dir_cpu_wr) begin
         cur.cpu.haddr = 32'h0000_1000; cur.cpu.hwrite = 1'b1;
         cur.cpu.hwdata = 32'hC0DE_0001; cur.cpu.htrans = HTRANS_NONSEQ;
      end
      if (dir_ld_wr) begin
         cur.ld.haddr = 32'h0000_0040; cur.ld.hwrite = 1'b1; cur.ld.hwdata = 32'hDEAD_BEEF;
      end
      apply(cur);
      if (!rstn) model_reset();
      q.push_back(model_expect(cur));
      prev = cur;
   endtask

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endfunction

   always @(negedge HCLK) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("HADDR",          HADDR,                 e.bus.haddr);
         chk("HBURST",         32'(HBURST),           32'(e.bus.hburst));
         chk("HMASTLOCK",      32'(HMASTLOCK),        32'(e.bus.hmastlock));
         chk("HPROT",          32'(HPROT),            32'(e.bus.hprot));
         chk("HSIZE",          32'(HSIZE),            32'(e.bus.hsize));
         chk("HTRANS",         32'(HTRANS),           32'(e.bus.htrans));
         chk("HWDATA",         HWDATA,                e.bus.hwdata);
         chk("HWRITE",         32'(HWRITE),           32'(e.bus.hwrite));
         chk("cpu_HREADY",     32'(cpu_HREADY),       32'(e.cpu_hready));
         chk("cpu_reset_n",    32'(cpu_reset_n),      32'(e.cpu_reset_n));
         chk("load_count",     32'(load_count),       32'(e.loads));
         chk("loader_overrun", 32'(loader_overrun),   32'(e.overrun));
      end
   end

   initial begin
      bit rb;
      dir_cpu_wr = 0; dir_ld_wr = 0;
      cur = '{rstn: 1'b0, busy: 1'b0, hready: 1'b1, cpu: '0, ld: '0};
      apply(cur);
      prev = cur;
      model_reset();

      // Reset, then plain release with no loader activity.
      repeat (3) step(0, 0, 1, 2'b00);
      repeat (24) step(1, 0, 1'($urandom_range(0, 3) != 0), 2'b00);

      // CPU write stalled by HREADY low while the loader takes over.
      dir_cpu_wr = 1;
      step(1, 0, 1, 2'b00);
      step(1, 1, 0, 2'b00);
      dir_cpu_wr = 0;
      repeat (3) step(1, 1, 0, 2'b00);
      step(1, 1, 1, 2'b00);
      dir_ld_wr = 1;
      repeat (3) step(1, 1, 1'($urandom), HTRANS_NONSEQ);
      dir_ld_wr = 0;
      repeat (20) step(1, 0, 1, 2'b00);

      // Loader violates its contract during DRAIN.
      repeat (2) step(1, 1, 0, HTRANS_NONSEQ);
      step(1, 1, 1, 2'b00);
      repeat (20) step(1, 0, 1, 2'b00);

      // Mid-operation reset while the loader owns the bus.
      repeat (4) step(1, 1, 1, HTRANS_NONSEQ);
      repeat (2) step(0, 1, 1, HTRANS_NONSEQ);
      repeat (20) step(1, 0, 1, 2'b00);

      // Randomized traffic with occasional resets.
      rb = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) rb = ~rb;
         step($urandom_range(0, 399) != 0, rb, $urandom_range(0, 3) != 0,
              ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00);
      end

      // 256 short sessions from a clean reset: load_count wraps back to 0.
      step(0, 0, 1, 2'b00);
      for (int i = 0; i < 256; i++) begin
         repeat (2) step(1, 1, 1'($urandom), 2'($urandom));
         step(1, 0, 1'($urandom), 2'b00);
      end
      repeat (20) step(1, 0, 1, 2'b00);

      @(negedge HCLK);
      #1;
      if (q.size() != 0) chk("queue_drain", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
